reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// ResetSequencer
//
// Purpose:
//   Orders the release of the board resets after the pixel PLL locks.
//   Both domains are held in reset for HOLD_CYCLES once lock is seen.
//   The video path is then released first.
//   The SoC follows STAGGER_CYCLES later.
//   Losing lock, a debounced button press or a software request restarts the
//   sequence, and the reason is recorded in reset_cause_o.
//
// Ports:
//   clk             pixel clock; every flop in this block runs on it
//   reset_ni        synchronous active-low block reset
//   pll_locked_i    PLL lock flag, asynchronous to clk
//   btn_reset_ni    raw, bouncing, active-low reset button (asynchronous)
//   sw_reset_req_i  single-cycle software reset request, synchronous to clk
//   video_reset_o   active-high reset for the HDMI/video path
//   soc_reset_o     active-high reset for the SoC
//   ready_o         high only while both domains are running
//   reset_cause_o   cause of the last reset:
//                   0 power-on, 1 button, 2 PLL loss, 3 software
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int HOLD_CYCLES     = 32,
  parameter int STAGGER_CYCLES  = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       pll_locked_i,
  input  logic       btn_reset_ni,
  input  logic       sw_reset_req_i,
  output logic       video_reset_o,
  output logic       soc_reset_o,
  output logic       ready_o,
  output logic [1:0] reset_cause_o
);

  // The hold counter is shared by the HOLD and STAGGER phases.
  // It must therefore reach the larger of the two terminal values.
  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [DW-1:0] DEB_FULL     = DW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] STAGGER   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_PLL = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  logic [1:0]    pllSync_q;
  logic [1:0]    btnSync_q;
  logic [DW-1:0] debCnt_q, debCnt_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          videoReset_q, socReset_q, ready_q;

  logic lockSync;
  logic btnSyncN;
  logic btnPressed;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  // They clear to 0 in reset, so outputs never depend on the PLL state while
  // the block is held in reset.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      pllSync_q <= 2'b00;
      btnSync_q <= 2'b00;
    end else begin
      pllSync_q <= {pllSync_q[0], pll_locked_i};
      btnSync_q <= {btnSync_q[0], btn_reset_ni};
    end
  end

  assign lockSync = pllSync_q[1];
  assign btnSyncN = btnSync_q[1];

  // The debouncer counts consecutive low samples of the synchronized button.
  // It saturates at the threshold, so a held button reads as pressed
  // indefinitely.
  // Any high sample throws the count away, which is what rejects bounce.
  always_comb begin
    debCnt_d = debCnt_q;
    if (btnSyncN) begin
      debCnt_d = '0;
    end else if (debCnt_q != DEB_FULL) begin
      debCnt_d = debCnt_q + DW'(1);
    end
  end

  assign btnPressed = (debCnt_q == DEB_FULL);

  // Sequencing FSM.
  // The case statement handles the normal counter-driven progress.
  // The trigger chain after it overrides that progress.
  // So a trigger landing on a terminal-count edge always wins.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    cause_d   = cause_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lockSync) begin
          state_d   = HOLD;
          holdCnt_d = '0;
        end
      end
      HOLD: begin
        // A held button parks the count at zero.
        // The full hold period is then measured from the release.
        if (btnPressed) begin
          holdCnt_d = '0;
        end else if (holdCnt_q == HOLD_LAST) begin
          state_d   = STAGGER;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + CW'(1);
        end
      end
      STAGGER: begin
        if (holdCnt_q == STAGGER_LAST) begin
          state_d   = RUN;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + CW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d   = WAIT_LOCK;
        holdCnt_d = '0;
      end
    endcase

    if ((state_q != WAIT_LOCK) && !lockSync) begin
      state_d   = WAIT_LOCK;
      holdCnt_d = '0;
      cause_d   = CAUSE_PLL;
    end else if (((state_q == STAGGER) || (state_q == RUN)) && btnPressed) begin
      state_d   = HOLD;
      holdCnt_d = '0;
      cause_d   = CAUSE_BTN;
    end else if ((state_q == RUN) && sw_reset_req_i) begin
      state_d   = HOLD;
      holdCnt_d = '0;
      cause_d   = CAUSE_SW;
    end
  end

  // State, counters and the registered outputs.
  // The outputs are decoded from the next state.
  // This lets them move on the same edge as the transition that causes them.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q      <= WAIT_LOCK;
      holdCnt_q    <= '0;
      debCnt_q     <= '0;
      cause_q      <= 2'd0;
      videoReset_q <= 1'b1;
      socReset_q   <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdCnt_q    <= holdCnt_d;
      debCnt_q     <= debCnt_d;
      cause_q      <= cause_d;
      videoReset_q <= (state_d == WAIT_LOCK) || (state_d == HOLD);
      socReset_q   <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign video_reset_o = videoReset_q;
  assign soc_reset_o   = socReset_q;
  assign ready_o       = ready_q;
  assign reset_cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// TbResetSequencer
//
// Purpose:
//   Self-checking bench for reset_sequencer with its default parameters.
//   A behavioural model tracks the following state:
//   - whether the sequencer is waiting for lock
//   - how many cycles the current release sequence has been running
//   - the length of the current synchronized low run on the button
//   - the last cause
//   The expected outputs are derived arithmetically from those values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int HOLD = 32;
  localparam int STAG = 8;
  localparam int DEB  = 16;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       pll;
  logic       btn;
  logic       sw;
  logic       videoReset;
  logic       socReset;
  logic       ready;
  logic [1:0] cause;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit         mWaiting;
  int         mElapsed;
  int         mLowRun;
  logic [1:0] mCause;
  logic [1:0] mPllPipe;
  logic [1:0] mBtnPipe;

  reset_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .STAGGER_CYCLES (STAG),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk           (clk),
    .reset_ni      (reset_ni),
    .pll_locked_i  (pll),
    .btn_reset_ni  (btn),
    .sw_reset_req_i(sw),
    .video_reset_o (videoReset),
    .soc_reset_o   (socReset),
    .ready_o       (ready),
    .reset_cause_o (cause)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge.
  // The model uses the input values the DUT samples at that edge.
  task automatic modelEdge();
    bit lockS;
    bit pressed;
    bit inHold;
    bit inStag;
    bit inRun;
    if (!reset_ni) begin
      mWaiting = 1'b1;
      mElapsed = 0;
      mLowRun  = 0;
      mCause   = 2'd0;
      mPllPipe = 2'b00;
      mBtnPipe = 2'b00;
      return;
    end
    lockS   = mPllPipe[1];
    pressed = (mLowRun >= DEB);
    inRun   = !mWaiting && (mElapsed >= HOLD + STAG);
    inStag  = !mWaiting && (mElapsed >= HOLD) && !inRun;
    inHold  = !mWaiting && (mElapsed < HOLD);
    if (!mWaiting && !lockS) begin
      mWaiting = 1'b1;
      mCause   = 2'd2;
    end else if ((inStag || inRun) && pressed) begin
      mElapsed = 0;
      mCause   = 2'd1;
    end else if (inRun && sw) begin
      mElapsed = 0;
      mCause   = 2'd3;
    end else if (mWaiting) begin
      if (lockS) begin
        mWaiting = 1'b0;
        mElapsed = 0;
      end
    end else if (inHold && pressed) begin
      mElapsed = 0;
    end else if (mElapsed < HOLD + STAG) begin
      mElapsed++;
    end
    mLowRun  = mBtnPipe[1] ? 0 : ((mLowRun < DEB) ? mLowRun + 1 : DEB);
    mPllPipe = {mPllPipe[0], pll};
    mBtnPipe = {mBtnPipe[0], btn};
  endtask

  task automatic checkOutput();
    logic expVideo;
    logic expSoc;
    expVideo = mWaiting || (mElapsed < HOLD);
    expSoc   = mWaiting || (mElapsed < HOLD + STAG);
    check1("model_video", videoReset, expVideo);
    check1("model_soc",   socReset,   expSoc);
    check1("model_ready", ready,      !expSoc);
    check2("model_cause", cause,      mCause);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  // Tick until the model reaches a given point in the release sequence.
  // The wait is bounded by a cycle budget.
  task automatic waitElapsed(input int target, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!mWaiting && (mElapsed == target)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1);
    end
    check1("wait_sequence_point", found, 1'b1);
  endtask

  initial begin
    reset_ni = 1'b0;
    pll      = 1'b0;
    btn      = 1'b1;
    sw       = 1'b0;
    applyStimulus(3);
    check1("rst_video", videoReset, 1'b1);
    check1("rst_soc",   socReset,   1'b1);
    check1("rst_ready", ready,      1'b0);
    check2("rst_cause", cause,      2'd0);

    // Power-up: lock present before the first released edge
    $display("[TB] power-up sequence");
    pll      = 1'b1;
    reset_ni = 1'b1;
    applyStimulus(34);
    check1("pu_video_e34", videoReset, 1'b1);
    applyStimulus(1);
    check1("pu_video_e35", videoReset, 1'b0);
    check1("pu_soc_e35",   socReset,   1'b1);
    applyStimulus(7);
    check1("pu_soc_e42",   socReset,   1'b1);
    applyStimulus(1);
    check1("pu_soc_e43",   socReset,   1'b0);
    check1("pu_ready_e43", ready,      1'b1);
    check2("pu_cause",     cause,      2'd0);

    // Lock loss in RUN, then relock
    $display("[TB] lock loss");
    applyStimulus(5);
    pll = 1'b0;
    applyStimulus(2);
    check1("ll_ready_e2", ready, 1'b1);
    applyStimulus(1);
    check1("ll_video_e3", videoReset, 1'b1);
    check1("ll_soc_e3",   socReset,   1'b1);
    check1("ll_ready_e3", ready,      1'b0);
    check2("ll_cause",    cause,      2'd2);
    pll = 1'b1;
    applyStimulus(34);
    check1("relock_video_e34", videoReset, 1'b1);
    applyStimulus(1);
    check1("relock_video_e35", videoReset, 1'b0);
    applyStimulus(8);
    check1("relock_ready_e43", ready, 1'b1);

    // Button bounce, then a real press held for 100 cycles
    $display("[TB] button bounce and press");
    applyStimulus(3);
    btn = 1'b0;
    applyStimulus(10);
    btn = 1'b1;
    applyStimulus(20);
    check1("bounce_ready", ready, 1'b1);
    btn = 1'b0;
    applyStimulus(18);
    check1("press_ready_pre", ready, 1'b1);
    applyStimulus(1);
    check1("press_video", videoReset, 1'b1);
    check2("press_cause", cause,      2'd1);
    applyStimulus(81);
    btn = 1'b1;
    applyStimulus(34);
    check1("release_video_e34", videoReset, 1'b1);
    applyStimulus(1);
    check1("release_video_e35", videoReset, 1'b0);
    applyStimulus(8);
    check1("release_ready", ready, 1'b1);

    // Software reset in RUN, then a pulse during STAGGER that must be ignored
    $display("[TB] software reset");
    applyStimulus(4);
    sw = 1'b1;
    applyStimulus(1);
    sw = 1'b0;
    check1("sw_video", videoReset, 1'b1);
    check1("sw_soc",   socReset,   1'b1);
    check2("sw_cause", cause,      2'd3);
    applyStimulus(31);
    check1("sw_video_e32", videoReset, 1'b1);
    applyStimulus(1);
    check1("sw_video_e33", videoReset, 1'b0);
    applyStimulus(7);
    check1("sw_soc_e40", socReset, 1'b1);
    applyStimulus(1);
    check1("sw_soc_e41", socReset, 1'b0);
    pll = 1'b0;
    applyStimulus(4);
    pll = 1'b1;
    waitElapsed(HOLD + 2, 200);
    sw = 1'b1;
    applyStimulus(1);
    sw = 1'b0;
    check1("sw_stag_video", videoReset, 1'b0);
    check2("sw_stag_cause", cause,      2'd2);

    // Lock loss, button press and software request on the same edge
    $display("[TB] simultaneous triggers");
    waitElapsed(HOLD + STAG, 200);
    btn = 1'b0;
    applyStimulus(16);
    pll = 1'b0;
    applyStimulus(2);
    sw = 1'b1;
    applyStimulus(1);
    sw = 1'b0;
    check2("simul_cause", cause,      2'd2);
    check1("simul_video", videoReset, 1'b1);
    btn = 1'b1;
    pll = 1'b1;

    // Button press landing on the STAGGER terminal edge
    waitElapsed(HOLD + STAG - 1 - (DEB + 2), 200);
    btn = 1'b0;
    applyStimulus(DEB + 2);
    check1("term_video_pre", videoReset, 1'b0);
    check1("term_soc_pre",   socReset,   1'b1);
    applyStimulus(1);
    check1("term_video", videoReset, 1'b1);
    check1("term_ready", ready,      1'b0);
    check2("term_cause", cause,      2'd1);
    btn = 1'b1;

    // Block reset pulsed in the middle of STAGGER
    $display("[TB] mid-sequence reset");
    waitElapsed(HOLD + 2, 200);
    reset_ni = 1'b0;
    applyStimulus(1);
    check1("mid_video", videoReset, 1'b1);
    check1("mid_soc",   socReset,   1'b1);
    check2("mid_cause", cause,      2'd0);
    reset_ni = 1'b1;
    applyStimulus(34);
    check1("mid_video_e34", videoReset, 1'b1);
    applyStimulus(1);
    check1("mid_video_e35", videoReset, 1'b0);

    // Randomized mix of triggers, glitches and idle stretches
    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(int'($urandom_range(1, 60)));
        1: begin
          sw = 1'b1;
          applyStimulus(1);
          sw = 1'b0;
          applyStimulus(int'($urandom_range(1, 30)));
        end
        2: begin
          btn = 1'b0;
          applyStimulus(int'($urandom_range(1, 30)));
          btn = 1'b1;
          applyStimulus(int'($urandom_range(3, 20)));
        end
        default: begin
          pll = 1'b0;
          applyStimulus(int'($urandom_range(1, 6)));
          pll = 1'b1;
          applyStimulus(int'($urandom_range(1, 50)));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
